spart: RTL
==========

Name: spart

Overview:
- Bus-side peripheral (SPART: special-purpose UART) that answers the user-IO CPU's iocs/iorw/ioaddr/databus transactions.
- Serialises written bytes onto txd and deserialises rxd into a receive buffer.
- Reports rda/tbr status and owns the programmable baud divisor.
- Sits between the user-IO CPU and the board serial pins.

Parameters:
- DEFAULT_DIV, 16'd325: divisor loaded at reset (50 MHz clock, 9600 baud, 16x oversample).
- OVERSAMPLE, 16: baud ticks per serial bit; RX samples at tick OVERSAMPLE/2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- iocs  input  1  chip select; a transaction occurs on any cycle with iocs=1
- iorw  input  1  1=CPU read, 0=CPU write
- ioaddr  input  2  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  driven by spart only when iocs&iorw, otherwise high-Z
- rda  output  1  receive data available
- tbr  output  1  transmit buffer ready
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous

Behaviour:
- Reset values: txd=1, tbr=1, rda=0, rx_buf=0, overrun=0, ferr=0, divisor=DEFAULT_DIV, baud counter reloaded, both FSMs idle, databus high-Z.
- Reset mid-frame aborts the frame and drives txd=1 on the next cycle.
- Reads are combinational: databus valid in the same cycle iocs&iorw.
  - Addr 00 returns rx_buf.
  - Addr 01 returns {4'b0, ferr, overrun, tbr, rda}.
  - Addr 10 returns divisor[7:0]; addr 11 returns divisor[15:8].
- Writes: databus sampled at the clock edge when iocs&~iorw.
  - Addr 00 with tbr=1: latch tx byte, tbr=0 next cycle.
  - Addr 00 with tbr=0: write ignored.
  - Addr 01: ignored.
  - Addr 10/11: update that divisor byte and reload the baud counter.
- Side effects on read (applied at the clock edge):
  - Read of addr 00 clears rda and overrun.
  - Read of addr 01 clears ferr.
- Baud generator: down-counter reloaded with divisor; emits a 1-cycle tick when it reaches 1, so a tick occurs every divisor cycles. Divisor 0 behaves as 1 (tick every cycle).
- TX FSM:
  - IDLE -> START on the first tick after a byte is latched.
  - START, DATA0..7 (LSB first), STOP; each bit is held for OVERSAMPLE ticks.
  - tbr=1 in the cycle after the STOP bit completes; FSM then returns to IDLE.
- RX FSM:
  - rxd passes through a 2-flop synchroniser.
  - IDLE -> START on a synchronised 1->0 edge.
  - START: sample after OVERSAMPLE/2 ticks. If high, false start: return to IDLE with no flag change.
  - DATA: 8 samples, OVERSAMPLE ticks apart, LSB first.
  - STOP sample = 1: load rx_buf, rda=1 next cycle. If rda was already 1, set overrun=1 and the new byte overwrites rx_buf.
  - STOP sample = 0: byte discarded, ferr=1.
  - Return to IDLE after the STOP sample.
- Simultaneous rx_buf load and addr-00 read in the same cycle: the read returns the old byte; rda stays 1 with the new byte; overrun is not set.
- Divisor write mid-frame: takes effect immediately; the frame in progress is allowed to corrupt.
- TX and RX are fully independent; a loopback of txd to rxd is legal.

Decomposition:
- spart_pkg holds:
  - address constants ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH;
  - status bit indices;
  - TX/RX state enums;
  - DEFAULT_DIV.
- Sub-module spart_baud_gen: divisor register, reload-on-write, tick output.
- TX FSM, RX FSM and bus decode live in spart.

Test Plan:
- Reset -> txd=1, tbr=1, rda=0, status read 8'h02, divisor reads 8'h45/8'h01, databus high-Z when iocs=0.
- Write divisor 0x0001, write 0xA5 to addr 00 -> tbr=0 next cycle; txd shows start bit, then 1,0,1,0,0,1,0,1, then stop bit, each 16 cycles wide; tbr=1 one cycle after the 160-cycle frame.
- Divisor 1, drive rxd with frame for 0x3C (16 cycles/bit) -> rda=1 after stop sample, addr-00 read returns 8'h3C, rda=0 next cycle.
- Two rx frames 0x11, 0x22 with no read -> status 8'h07, addr-00 returns 8'h22, subsequent status 8'h02.
- 4-cycle low glitch on rxd -> no rda, no ferr; frame 0x55 with stop bit low -> rda stays 0, status bit3=1, cleared after status read.
- Write 0x7E, assert rst at frame midpoint -> txd=1, tbr=1 next cycle; write during busy (tbr=0) is ignored and only the first byte is sent.

Source files
------------

// File: rtl/spart_pkg.sv
// spart_pkg: shared constants, state types and helpers for the SPART block.
//   - Bus register addresses (ADDR_*)
//   - Status byte bit positions (STAT_*)
//   - TX / RX FSM state enums
//   - Reset divisor and oversample ratio
package spart_pkg;

  // 50 MHz clock, 9600 baud, 16x oversample.
  localparam logic [15:0] DEFAULT_DIV = 16'd325;
  localparam int          OVERSAMPLE  = 16;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int STAT_RDA  = 0;
  localparam int STAT_TBR  = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_FERR = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Assemble the status register: upper nibble always zero.
  function automatic logic [7:0] status_byte(input logic ferr, input logic ovr,
                                             input logic tbr, input logic rda);
    logic [7:0] s;
    s            = 8'h00;
    s[STAT_RDA]  = rda;
    s[STAT_TBR]  = tbr;
    s[STAT_OVR]  = ovr;
    s[STAT_FERR] = ferr;
    return s;
  endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: programmable baud tick generator.
//   clk, rst     : clock, synchronous active-high reset
//   wr_lo, wr_hi : write strobe for divisor low / high byte
//   wr_data      : byte written into the selected divisor half
//   divisor      : current divisor (read back over the bus)
//   tick         : one-cycle pulse every max(divisor,1) cycles
module spart_baud_gen #(
  parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [7:0]  wr_data,
  output logic [15:0] divisor,
  output logic        tick
);
  import spart_pkg::*;

  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    div_d = div_q;
    if (wr_lo) div_d[7:0]  = wr_data;
    if (wr_hi) div_d[15:8] = wr_data;

    // Counting down to 1 gives a period of exactly div cycles; a divisor
    // of 0 keeps the counter at 0, which also ticks every cycle.
    tick = (cnt_q <= 16'd1);

    if (wr_lo || wr_hi) begin
      cnt_d = div_d;           // new rate applies immediately
    end else if (tick) begin
      cnt_d = div_q;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
      cnt_q <= DEFAULT_DIV;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign divisor = div_q;

endmodule

// File: rtl/spart.sv
// spart: bus-attached UART for the user-IO CPU.
//   clk, rst : clock, synchronous active-high reset
//   iocs     : chip select, a transaction happens on every cycle it is high
//   iorw     : 1 = CPU read, 0 = CPU write
//   ioaddr   : 00 data buffer, 01 status, 10 divisor low, 11 divisor high
//   databus  : bidirectional; driven only while iocs & iorw
//   rda, tbr : receive data available, transmit buffer ready
//   txd, rxd : serial out (idle high), asynchronous serial in
module spart #(
  parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV,
  parameter int          OVERSAMPLE  = spart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  import spart_pkg::*;

  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);

  // ---------------------------------------------------------------- bus
  logic       rd_en, wr_en;
  logic       rd_buf, rd_stat, wr_buf;
  logic [7:0] rd_data;
  logic [15:0] divisor;
  logic       tick;

  assign rd_en   = iocs & iorw;
  assign wr_en   = iocs & ~iorw;
  assign rd_buf  = rd_en && (ioaddr == ADDR_BUF);
  assign rd_stat = rd_en && (ioaddr == ADDR_STAT);
  assign wr_buf  = wr_en && (ioaddr == ADDR_BUF);

  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rda_q, rda_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic       tbr_q, tbr_d, txd_q, txd_d;

  always_comb begin
    case (ioaddr)
      ADDR_BUF:  rd_data = rx_buf_q;
      ADDR_STAT: rd_data = status_byte(ferr_q, ovr_q, tbr_q, rda_q);
      ADDR_DBL:  rd_data = divisor[7:0];
      default:   rd_data = divisor[15:8];
    endcase
  end

  assign databus = rd_en ? rd_data : 8'bz;

  spart_baud_gen #(.DEFAULT_DIV(DEFAULT_DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .wr_lo   (wr_en && (ioaddr == ADDR_DBL)),
    .wr_hi   (wr_en && (ioaddr == ADDR_DBH)),
    .wr_data (databus),
    .divisor (divisor),
    .tick    (tick)
  );

  // ---------------------------------------------------------------- TX
  tx_state_e         tx_state_q, tx_state_d;
  logic [TICK_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_idx_q, tx_idx_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_bit_end;

  assign tx_bit_end = tick && (tx_cnt_q == TICK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tbr_q      <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tbr_q      <= tbr_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tbr_d      = tbr_q;

    if (tick && (tx_state_q != TX_IDLE)) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + TICK_W'(1);
    end

    case (tx_state_q)
      TX_IDLE: begin
        // tbr low in IDLE means a byte is latched and waiting for a tick.
        if (wr_buf && tbr_q) begin
          tx_shift_d = databus;
          tbr_d      = 1'b0;
        end else if (!tbr_q && tick) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_idx_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_idx_d   = tx_idx_q + 3'd1;
        end
      end
      default: begin
        if (tx_bit_end) begin
          tx_state_d = TX_IDLE;
          tbr_d      = 1'b1;
        end
      end
    endcase
  end

  // txd is registered from the next state so the pin never glitches.
  always_comb begin
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX
  rx_state_e         rx_state_q, rx_state_d;
  logic [TICK_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_idx_q, rx_idx_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  logic              rx_fall, rx_half, rx_full;
  logic              rx_done_ok, rx_done_bad;

  assign rx_fall = rx_prev_q & ~rx_sync_q;
  assign rx_half = tick && (rx_cnt_q == TICK_HALF);
  assign rx_full = tick && (rx_cnt_q == TICK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_buf_q   <= '0;
      rda_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;

    if (tick && (rx_state_q != RX_IDLE)) rx_cnt_d = rx_cnt_q + TICK_W'(1);

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid-bit check rejects glitches shorter than half a bit.
        if (rx_half) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_idx_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_full) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end
      end
      default: begin
        if (rx_full) rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_done_ok  = (rx_state_q == RX_STOP) && rx_full && rx_sync_q;
    rx_done_bad = (rx_state_q == RX_STOP) && rx_full && !rx_sync_q;

    rx_buf_d = rx_done_ok ? rx_shift_q : rx_buf_q;

    // A load wins over the read-clear, so a byte arriving during a buffer
    // read stays flagged; the read still clears overrun.
    if (rx_done_ok)  rda_d = 1'b1;
    else if (rd_buf) rda_d = 1'b0;
    else             rda_d = rda_q;

    if (rd_buf)                  ovr_d = 1'b0;
    else if (rx_done_ok && rda_q) ovr_d = 1'b1;
    else                         ovr_d = ovr_q;

    if (rx_done_bad)  ferr_d = 1'b1;
    else if (rd_stat) ferr_d = 1'b0;
    else              ferr_d = ferr_q;
  end

  assign rda = rda_q;
  assign tbr = tbr_q;
  assign txd = txd_q;

endmodule
